hazard_monitor: RTL
===================

Name: hazard_monitor

Overview:
- Parametrised collision and lives manager for N moving cars against the raccoon sprite. It replaces the fixed five-car combinational hitbox check and the free-running lives decrement.
- Registers the per-car overlap, debounces hits through a post-hit invulnerability window and owns the lives counter. Drives game-over, a hit pulse and a sprite blink flag.
- Sits between the car_ctrl instances / raccoon_ctrl and the game_state, LED_control and vga blocks.

Parameters:
- NUM_CARS, 5, number of car channels checked.
- X_W, 10, horizontal coordinate width.
- Y_W, 10, vertical coordinate width; car Y inputs are Y_W-1 bits, zero-extended.
- PLAYER_W, 32, raccoon hitbox width in pixels.
- PLAYER_H, 32, raccoon hitbox height.
- CAR_W, 32, car hitbox width.
- CAR_H, 32, car hitbox height.
- MAX_LIVES, 3, lives loaded at reset, range 1..15.
- LIVES_W, 4, lives counter width.
- GRACE_CYCLES, 25_000_000, invulnerability length in clocks (1 s at 25 MHz), minimum 2.
- BLINK_BIT, 21, bit of the grace counter driving o_Blink.

Ports:
- i_Clk  in  1  system clock, 25 MHz.
- i_Reset  in  1  synchronous, active-high; restores lives and state.
- i_Enable  in  1  game running (game_state == running); gates hits and the grace countdown.
- i_Raccoon_X  in  X_W  player left edge.
- i_Raccoon_Y  in  Y_W  player top edge.
- i_Car_X  in  NUM_CARS*X_W  flattened car X; car k in bits [k*X_W +: X_W].
- i_Car_Y  in  NUM_CARS*(Y_W-1)  flattened car Y, same packing.
- o_Hit_Mask  out  NUM_CARS  registered per-car overlap, unfiltered.
- o_Hit_Pulse  out  1  one-cycle pulse per accepted hit.
- o_Hit_Car  out  NUM_CARS  mask captured at the last accepted hit.
- o_Lives  out  LIVES_W  remaining lives.
- o_Invulnerable  out  1  high while in GRACE.
- o_Blink  out  1  sprite blink flag.
- o_Game_Over  out  1  high in DEAD.

Behaviour:
- Synchronous, active-high reset; all state on the rising edge of i_Clk. i_Reset has priority over every other event, including mid-GRACE and DEAD.
- Reset values:
  - o_Hit_Mask = 0, o_Hit_Pulse = 0, o_Hit_Car = 0.
  - o_Lives = MAX_LIVES, o_Invulnerable = 0, o_Blink = 0, o_Game_Over = 0.
  - State ALIVE, grace counter 0.
- Stage 1 (overlap), for each car k:
  - Overlap condition: px < cx+CAR_W and px+PLAYER_W > cx and py < cy+CAR_H and py+PLAYER_H > cy.
  - All sums use X_W+1 / Y_W+1 bits so cars near the right or bottom edge (e.g. cx = 1000) never wrap.
  - Result is registered into o_Hit_Mask, latency 1.
  - Touching edges (px+PLAYER_W == cx) is not an overlap.
- Stage 2, FSM with states ALIVE, GRACE, DEAD:
  - ALIVE:
    - Hit accepted when i_Enable=1 and |o_Hit_Mask=1.
    - On a hit: o_Hit_Pulse=1 next cycle, o_Hit_Car <= o_Hit_Mask, o_Lives decrements by 1.
    - If o_Lives was 1: go to DEAD, o_Lives = 0.
    - Otherwise: go to GRACE, grace counter <= GRACE_CYCLES-1.
    - Several cars overlapping in the same cycle cost exactly one life.
  - GRACE:
    - o_Invulnerable=1; overlaps are ignored.
    - Counter decrements only while i_Enable=1 and holds otherwise.
    - At counter 0 with i_Enable=1: go to ALIVE.
    - If overlap persists on re-entry to ALIVE, a new hit is accepted on the first ALIVE cycle.
  - DEAD: o_Game_Over=1; o_Lives holds 0; no pulses; leaves only on i_Reset.
- Outputs per state:
  - o_Blink = grace counter bit BLINK_BIT when in GRACE, else 0.
  - o_Hit_Pulse is exactly one cycle wide; it never asserts in GRACE or DEAD.
- Hit-to-pulse latency: two clocks from the coordinate change (one overlap register, one FSM register).
- i_Enable low in ALIVE: no hits, lives frozen; o_Hit_Mask keeps updating.

Decomposition:
- Shared package holds the sprite and car dimension constants, the coordinate widths, MAX_LIVES and the FSM state encoding (ALIVE=2'b00, GRACE=2'b01, DEAD=2'b10). car_ctrl, vga and top use the same constants.
- One sub-module, aabb_overlap: purely combinational box test, parametrised by widths and box sizes. It is instantiated NUM_CARS times in a generate loop; the hazard_monitor owns the registers.

Test Plan:
- Bench parameters for all scenarios: GRACE_CYCLES=16, MAX_LIVES=3, BLINK_BIT=1.
- Reset then i_Enable=1, raccoon (100,100), car0 (120,110) -> o_Hit_Mask=5'b00001 after 1 clk, o_Hit_Pulse one cycle after that, o_Lives=2, o_Invulnerable=1, o_Hit_Car=5'b00001.
- Overlap held continuously -> exactly one pulse per 17-cycle window (16 GRACE cycles plus 1), o_Lives 3→2→1→0, then o_Game_Over=1 and no further pulses or decrements.
- Cars 1 and 3 overlap in the same cycle -> single pulse, o_Lives drops by 1, o_Hit_Car=5'b01010.
- Car at cx=1000 with raccoon at px=0 -> no overlap (no wrap); px+32 == cx -> o_Hit_Mask=0.
- i_Enable dropped for 10 cycles mid-GRACE -> counter and o_Blink frozen, GRACE lasts 26 cycles total; i_Reset asserted in DEAD -> next cycle o_Lives=3, o_Game_Over=0, state ALIVE.

Source files
------------

// File: rtl/hazard_monitor_pkg.sv
// Shared playfield constants and hazard FSM encoding for the raccoon game.
// car_ctrl, vga and hazard_monitor all size their boxes from these values.
package hazard_monitor_pkg;

    localparam int HM_NUM_CARS     = 5;
    localparam int HM_X_W          = 10;
    localparam int HM_Y_W          = 10;
    localparam int HM_PLAYER_W     = 32;
    localparam int HM_PLAYER_H     = 32;
    localparam int HM_CAR_W        = 32;
    localparam int HM_CAR_H        = 32;
    localparam int HM_MAX_LIVES    = 3;
    localparam int HM_LIVES_W      = 4;
    localparam int HM_GRACE_CYCLES = 25_000_000;
    localparam int HM_BLINK_BIT    = 21;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'b00,
        ST_GRACE = 2'b01,
        ST_DEAD  = 2'b10
    } hm_state_e;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box test between the player box and one car box.
// Far edges are computed one bit wider so boxes near the right/bottom never wrap.
module aabb_overlap
    import hazard_monitor_pkg::*;
#(
    parameter int X_W      = HM_X_W,
    parameter int Y_W      = HM_Y_W,
    parameter int PLAYER_W = HM_PLAYER_W,
    parameter int PLAYER_H = HM_PLAYER_H,
    parameter int CAR_W    = HM_CAR_W,
    parameter int CAR_H    = HM_CAR_H
) (
    input  logic [X_W-1:0] px_i,
    input  logic [Y_W-1:0] py_i,
    input  logic [X_W-1:0] cx_i,
    input  logic [Y_W-1:0] cy_i,
    output logic           overlap_o
);

    localparam logic [X_W:0] PW = (X_W+1)'(PLAYER_W);
    localparam logic [Y_W:0] PH = (Y_W+1)'(PLAYER_H);
    localparam logic [X_W:0] CW = (X_W+1)'(CAR_W);
    localparam logic [Y_W:0] CH = (Y_W+1)'(CAR_H);

    logic [X_W:0] px_e, cx_e, px_far, cx_far;
    logic [Y_W:0] py_e, cy_e, py_far, cy_far;

    assign px_e   = {1'b0, px_i};
    assign cx_e   = {1'b0, cx_i};
    assign py_e   = {1'b0, py_i};
    assign cy_e   = {1'b0, cy_i};
    assign px_far = px_e + PW;
    assign cx_far = cx_e + CW;
    assign py_far = py_e + PH;
    assign cy_far = cy_e + CH;

    // Strict compares: boxes that merely touch do not collide.
    assign overlap_o = (px_e < cx_far) && (px_far > cx_e) &&
                       (py_e < cy_far) && (py_far > cy_e);

endmodule

// File: rtl/hazard_monitor.sv
// Collision and lives manager: registers per-car overlap, filters hits through
// a post-hit invulnerability window and owns the lives counter.
//   state | meaning
//   ALIVE | hits accepted when enabled
//   GRACE | invulnerable, counting down the grace window
//   DEAD  | no lives left, waits for reset
module hazard_monitor
    import hazard_monitor_pkg::*;
#(
    parameter int NUM_CARS     = HM_NUM_CARS,
    parameter int X_W          = HM_X_W,
    parameter int Y_W          = HM_Y_W,
    parameter int PLAYER_W     = HM_PLAYER_W,
    parameter int PLAYER_H     = HM_PLAYER_H,
    parameter int CAR_W        = HM_CAR_W,
    parameter int CAR_H        = HM_CAR_H,
    parameter int MAX_LIVES    = HM_MAX_LIVES,
    parameter int LIVES_W      = HM_LIVES_W,
    parameter int GRACE_CYCLES = HM_GRACE_CYCLES,
    parameter int BLINK_BIT    = HM_BLINK_BIT
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_Enable,
    input  logic [X_W-1:0]            i_Raccoon_X,
    input  logic [Y_W-1:0]            i_Raccoon_Y,
    input  logic [NUM_CARS*X_W-1:0]   i_Car_X,
    input  logic [NUM_CARS*(Y_W-1)-1:0] i_Car_Y,
    output logic [NUM_CARS-1:0]       o_Hit_Mask,
    output logic                      o_Hit_Pulse,
    output logic [NUM_CARS-1:0]       o_Hit_Car,
    output logic [LIVES_W-1:0]        o_Lives,
    output logic                      o_Invulnerable,
    output logic                      o_Blink,
    output logic                      o_Game_Over
);

    // Counter must reach GRACE_CYCLES-1 and also expose the blink bit.
    localparam int CNT_W = ($clog2(GRACE_CYCLES) > BLINK_BIT) ? $clog2(GRACE_CYCLES) : BLINK_BIT + 1;
    localparam logic [CNT_W-1:0]   GRACE_LOAD = CNT_W'(GRACE_CYCLES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);

    logic [NUM_CARS-1:0] mask_d, mask_q;
    logic [NUM_CARS-1:0] hit_car_q;
    logic [LIVES_W-1:0]  lives_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pulse_q;
    hm_state_e           state_q;

    for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
        aabb_overlap #(
            .X_W      (X_W),
            .Y_W      (Y_W),
            .PLAYER_W (PLAYER_W),
            .PLAYER_H (PLAYER_H),
            .CAR_W    (CAR_W),
            .CAR_H    (CAR_H)
        ) u_overlap (
            .px_i      (i_Raccoon_X),
            .py_i      (i_Raccoon_Y),
            .cx_i      (i_Car_X[k*X_W +: X_W]),
            .cy_i      ({1'b0, i_Car_Y[k*(Y_W-1) +: (Y_W-1)]}),
            .overlap_o (mask_d[k])
        );
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            mask_q    <= '0;
            hit_car_q <= '0;
            lives_q   <= LIVES_INIT;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
            state_q   <= ST_ALIVE;
        end else begin
            mask_q  <= mask_d;
            pulse_q <= 1'b0;
            case (state_q)
                ST_ALIVE: begin
                    // Any number of simultaneous overlaps costs a single life.
                    if (i_Enable && (|mask_q)) begin
                        pulse_q   <= 1'b1;
                        hit_car_q <= mask_q;
                        if (lives_q <= LIVES_W'(1)) begin
                            lives_q <= '0;
                            state_q <= ST_DEAD;
                        end else begin
                            lives_q <= lives_q - 1'b1;
                            cnt_q   <= GRACE_LOAD;
                            state_q <= ST_GRACE;
                        end
                    end
                end
                ST_GRACE: begin
                    if (i_Enable) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_ALIVE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    lives_q <= '0;
                end
                default: begin
                    state_q <= ST_ALIVE;
                end
            endcase
        end
    end

    assign o_Hit_Mask     = mask_q;
    assign o_Hit_Pulse    = pulse_q;
    assign o_Hit_Car      = hit_car_q;
    assign o_Lives        = lives_q;
    assign o_Invulnerable = (state_q == ST_GRACE);
    assign o_Blink        = (state_q == ST_GRACE) && cnt_q[BLINK_BIT];
    assign o_Game_Over    = (state_q == ST_DEAD);

endmodule
